nor_chain_pulse_gen: RTL
========================

// Module: nor_chain_pulse_gen
// PURPOSE
//  Stimulus transmitter for the NOR inverter-chain delay test structures. Drives the
//  chain input with a programmable train of high/low pulses so that degradation and
//  cancellation of short pulses can be measured at the chain output.
//  Sits between the test controller (start/done handshake) and the chain input pin.
// PARAMETERS
//  CNT_W    16  width of the phase-length counters and of high_len/low_len/sweep_step
//  NPULSE_W  8  width of the pulse-count field num_pulses
// PORTS
//  clk         in   1         single clock; all logic on rising edge
//  rst         in   1         synchronous, active-high reset
//  start       in   1         request one pulse train; sampled only in IDLE
//  high_len    in   CNT_W     active-phase length in cycles (0 treated as 1)
//  low_len     in   CNT_W     inactive-phase length in cycles (0 treated as 1)
//  num_pulses  in   NPULSE_W  pulses per train; 0 gives an empty train
//  pol         in   1         0: idle low, pulses high; 1: idle high, pulses low
//  sweep_step  in   CNT_W     per-pulse high_len decrement (PULSE_SWEEP_EN only)
//  chain_in    out  1         registered drive to chain input; reset value 0
//  busy        out  1         high from the cycle after start until done; reset value 0
//  done        out  1         one-cycle pulse at end of train; reset value 0
// BEHAVIOUR
//  - All outputs are registered. No combinational path from input to output.
//  - The FSM (st_e) has four states: IDLE, HIGH, LOW, DONE.
//  - IDLE: chain_in = pol. When start=1, latch high_len, low_len, num_pulses, pol and
//    sweep_step.
//    - If num_pulses != 0: go to HIGH.
//    - If num_pulses == 0: go to DONE.
//  - Start is latched at edge t. At edge t+1, chain_in = ~pol and busy = 1.
//  - HIGH: chain_in = ~pol for exactly max(high_len,1) cycles, then go to LOW.
//  - LOW: chain_in = pol for exactly max(low_len,1) cycles.
//    - After the phase, decrement the pulse counter.
//    - If pulses remain, go to HIGH. Otherwise go to DONE.
//  - DONE: done = 1 for one cycle; busy stays 1 in this cycle. Next state is IDLE with
//    busy = 0.
//  - A new start is accepted in the IDLE cycle right after DONE, so back-to-back trains
//    are separated by at least one idle cycle.
//  - Total train length (no sweep) = N*(H+L) cycles of busy before done. N, H and L
//    are the clamped values.
//  - start while busy is ignored and not queued.
//  - Configuration inputs are don't-care outside the start cycle. The latched copy is
//    used for the whole train.
//  - Phase counters load len-1 and count down to 0. No wrap is possible.
//    A len of (2^CNT_W - 1) is legal.
//  - rst at any point, including mid-pulse: the next edge forces IDLE, chain_in=0,
//    busy=0 and done=0.
//    - Note: this forces chain_in to 0 regardless of the latched pol.
//    - In the first IDLE cycle after reset release, chain_in follows the live pol input.
// CONFIGURATION
//  Macro PULSE_SWEEP_EN.
//  - Defined: after each HIGH phase, latched high_len -= sweep_step, saturating at 1.
//    This produces a train of shrinking pulses for cancellation sweeps.
//  - Undefined: sweep_step is unused (port kept, ignored) and every pulse has identical
//    width. No sweep logic is synthesised.
// STRUCTURE
//  - Package nor_chain_pkg holds:
//    - typedef enum st_e {IDLE, HIGH, LOW, DONE}
//    - default CNT_W and NPULSE_W localparams
//    - helper function clamp1(len), returning max(len,1)
//  - One sub-module: nor_chain_phase_cnt.
//    - Loadable CNT_W down-counter with load, en, and a registered zero flag.
//    - Instantiated once and shared by the HIGH and LOW phases.
// TESTING
//  1. pol=0, H=3, L=2, N=2, start@t:
//     - chain_in 1 on t+1..t+3, 0 on t+4..t+5, 1 on t+6..t+8, 0 on t+9..t+10.
//     - done@t+11.
//  2. N=0:
//     - busy 1 for exactly one cycle, with done in that same cycle.
//     - chain_in never leaves the idle level.
//  3. H=0, L=0, N=3, pol=1:
//     - chain_in alternates 0,1 for single cycles, three times.
//     - done 6 cycles after busy rises.
//  4. Assert start each cycle during a train: no restart and no extra done.
//     After done, one idle cycle, then the next start is accepted.
//  5. rst asserted during a HIGH phase with pol=1:
//     - The next edge gives chain_in=0, busy=0, done=0.
//     - After release, chain_in=1 (idle level) and no done is ever emitted.
//  6. PULSE_SWEEP_EN, H=5, step=2, L=1, N=4:
//     - High widths are 5, 3, 1, 1 cycles.
//     - With the macro undefined, widths are 5, 5, 5, 5.

Source files
------------

// File: rtl/nor_chain_pkg.sv
// rtl/nor_chain_pkg.sv - shared types, default widths and length clamp for the NOR chain pulse generator
package nor_chain_pkg;

    localparam int DEF_CNT_W    = 16;
    localparam int DEF_NPULSE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        DONE = 2'd3
    } st_e;

    // Zero-length phases are stretched to one cycle so a phase always exists.
    function automatic logic [31:0] clamp1(input logic [31:0] len);
        return (len == 32'd0) ? 32'd1 : len;
    endfunction

endpackage

// File: rtl/nor_chain_phase_cnt.sv
// rtl/nor_chain_phase_cnt.sv - loadable down-counter with registered zero flag, shared by HIGH and LOW phases
module nor_chain_phase_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    // Counting stops at zero, so a full-scale load can never wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            zero <= 1'b0;
        end else if (load) begin
            cnt  <= load_val;
            zero <= (load_val == '0);
        end else if (en && !zero) begin
            cnt  <= cnt - CNT_W'(1);
            zero <= (cnt == CNT_W'(1));
        end
    end

endmodule

// File: rtl/nor_chain_pulse_gen.sv
// rtl/nor_chain_pulse_gen.sv - programmable high/low pulse train driver for the NOR chain input
// Optional shrinking-pulse sweep enabled by macro PULSE_SWEEP_EN.
module nor_chain_pulse_gen
    import nor_chain_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int NPULSE_W = DEF_NPULSE_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CNT_W-1:0]    high_len,
    input  logic [CNT_W-1:0]    low_len,
    input  logic [NPULSE_W-1:0] num_pulses,
    input  logic                pol,
    input  logic [CNT_W-1:0]    sweep_step,
    output logic                chain_in,
    output logic                busy,
    output logic                done
);

    st_e                 state;
    logic [CNT_W-1:0]    high_q;
    logic [CNT_W-1:0]    low_q;
    logic [NPULSE_W-1:0] pulses_q;
    logic                pol_q;

    logic                cnt_load;
    logic                cnt_en;
    logic [CNT_W-1:0]    cnt_val;
    logic                cnt_zero;

`ifdef PULSE_SWEEP_EN
    logic [CNT_W-1:0]    step_q;
`else
    logic                unused_sweep;
    assign unused_sweep = ^sweep_step;
`endif

    nor_chain_phase_cnt #(.CNT_W(CNT_W)) u_phase_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .en       (cnt_en),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    always_comb begin
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        cnt_val  = high_q - CNT_W'(1);
        case (state)
            IDLE: begin
                if (start) begin
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(clamp1(32'(high_len))) - CNT_W'(1);
                end
            end
            HIGH: begin
                if (cnt_zero) begin
                    cnt_load = 1'b1;
                    cnt_val  = low_q - CNT_W'(1);
                end else begin
                    cnt_en = 1'b1;
                end
            end
            LOW: begin
                if (cnt_zero) begin
                    cnt_load = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            high_q   <= '0;
            low_q    <= '0;
            pulses_q <= '0;
            pol_q    <= 1'b0;
`ifdef PULSE_SWEEP_EN
            step_q   <= '0;
`endif
            chain_in <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        high_q   <= CNT_W'(clamp1(32'(high_len)));
                        low_q    <= CNT_W'(clamp1(32'(low_len)));
                        pulses_q <= num_pulses;
                        pol_q    <= pol;
`ifdef PULSE_SWEEP_EN
                        step_q   <= sweep_step;
`endif
                        state    <= (num_pulses == '0) ? DONE : HIGH;
                    end
                end
                HIGH: begin
                    if (cnt_zero) begin
                        state <= LOW;
`ifdef PULSE_SWEEP_EN
                        high_q <= (high_q > step_q) ? (high_q - step_q) : CNT_W'(1);
`endif
                    end
                end
                LOW: begin
                    if (cnt_zero) begin
                        if (pulses_q == NPULSE_W'(1)) begin
                            state <= DONE;
                        end else begin
                            pulses_q <= pulses_q - NPULSE_W'(1);
                            state    <= HIGH;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase

            // Outputs trail the state by one edge, so every pin is a plain flop.
            chain_in <= (state == IDLE) ? pol : ((state == HIGH) ? ~pol_q : pol_q);
            busy     <= (state != IDLE);
            done     <= (state == DONE);
        end
    end

endmodule
